// File: rtl/alu_sequencer.sv
// alu_sequencer: stack-machine sequencer for a single ALU instruction.
// It pops one or two operands from an external stack, lets an external
// combinational ALU compute the result, pushes the result back, and
// signals completion. Unsupported opcodes are rejected without touching the stack.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op_code,
    output logic        op_ready,
    output logic        stack_pop,
    input  logic        stack_pop_valid,
    input  logic [31:0] stack_pop_data,
    output logic        stack_push,
    input  logic        stack_push_ready,
    output logic [31:0] stack_push_data,
    output logic [31:0] alu_operand_a,
    output logic [31:0] alu_operand_b,
    output logic [3:0]  alu_op_select,
    input  logic [31:0] alu_result_lo,
    output logic        done,
    output logic        illegal_op
);

    localparam logic [3:0] OP_IADD = 4'b0000;
    localparam logic [3:0] OP_ISUB = 4'b0001;
    localparam logic [3:0] OP_INEG = 4'b0101;
    localparam logic [3:0] OP_IOR  = 4'b1000;
    localparam logic [3:0] OP_IXOR = 4'b1001;
    localparam logic [3:0] OP_ISHL = 4'b1100;
    localparam logic [3:0] OP_ISHR = 4'b1101;
    localparam logic [3:0] OP_IAND = 4'b1111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP_B = 3'd1,
        POP_A = 3'd2,
        EXEC  = 3'd3,
        PUSH  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] operand_a_q;
    logic [31:0] operand_b_q;
    logic [31:0] result_q;
    logic        stack_pop_q;
    logic        stack_push_q;
    logic        done_q;
    logic        illegal_q;
    logic        accept;

    function automatic logic isSupported(input logic [3:0] code);
        case (code)
            OP_IADD, OP_ISUB, OP_INEG, OP_IOR,
            OP_IXOR, OP_ISHL, OP_ISHR, OP_IAND: isSupported = 1'b1;
            default:                            isSupported = 1'b0;
        endcase
    endfunction

    // Ready only while idle; forced low while reset is held so nothing is accepted.
    assign op_ready = (state_q == IDLE) && !rst;
    assign accept   = op_valid && op_ready;

    assign stack_pop       = stack_pop_q;
    assign stack_push      = stack_push_q;
    assign stack_push_data = result_q;
    assign alu_operand_a   = operand_a_q;
    assign alu_operand_b   = operand_b_q;
    assign alu_op_select   = op_q;
    assign done            = done_q;
    assign illegal_op      = illegal_q;

    // Next-state selection; unary INEG skips the operand_b pop, rejected codes stay idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && isSupported(op_code)) begin
                    if (op_code == OP_INEG) begin
                        state_d = POP_A;
                    end else begin
                        state_d = POP_B;
                    end
                end
            end
            POP_B: begin
                if (stack_pop_valid) begin
                    state_d = POP_A;
                end
            end
            POP_A: begin
                if (stack_pop_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = PUSH;
            end
            PUSH: begin
                if (stack_push_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath registers and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 4'b0000;
            operand_a_q  <= 32'h0;
            operand_b_q  <= 32'h0;
            result_q     <= 32'h0;
            stack_pop_q  <= 1'b0;
            stack_push_q <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            stack_pop_q  <= (state_d == POP_B) || (state_d == POP_A);
            stack_push_q <= (state_d == PUSH);
            done_q       <= (state_d == DONE);
            illegal_q    <= accept && !isSupported(op_code);

            if (accept) begin
                op_q <= op_code;
                if (op_code == OP_INEG) begin
                    operand_b_q <= 32'h0;
                end
            end

            if ((state_q == POP_B) && stack_pop_valid) begin
                operand_b_q <= stack_pop_data;
            end

            if ((state_q == POP_A) && stack_pop_valid) begin
                operand_a_q <= stack_pop_data;
            end

            if (state_q == EXEC) begin
                result_q <= alu_result_lo;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed, table-driven bench for alu_sequencer with a
// behavioural ALU and a configurable-latency stack model.
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op_code;
    logic        op_ready;
    logic        stack_pop;
    logic        stack_pop_valid;
    logic [31:0] stack_pop_data;
    logic        stack_push;
    logic        stack_push_ready;
    logic [31:0] stack_push_data;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic [3:0]  alu_op_select;
    logic [31:0] alu_result_lo;
    logic        done;
    logic        illegal_op;

    int assertCount = 0;
    int failCount   = 0;
    int overlapCount = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] top;
        logic [31:0] second;
        int          popDelay;
        int          pushDelay;
        logic [31:0] expPush;
        logic [31:0] expA;
        logic [31:0] expB;
        int          expPops;
        int          expDone;
    } vec_t;

    vec_t vecs[10];

    alu_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .op_valid         (op_valid),
        .op_code          (op_code),
        .op_ready         (op_ready),
        .stack_pop        (stack_pop),
        .stack_pop_valid  (stack_pop_valid),
        .stack_pop_data   (stack_pop_data),
        .stack_push       (stack_push),
        .stack_push_ready (stack_push_ready),
        .stack_push_data  (stack_push_data),
        .alu_operand_a    (alu_operand_a),
        .alu_operand_b    (alu_operand_b),
        .alu_op_select    (alu_op_select),
        .alu_result_lo    (alu_result_lo),
        .done             (done),
        .illegal_op       (illegal_op)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External combinational ALU; INEG is taken as bitwise complement.
    always_comb begin
        alu_result_lo = 32'h0;
        case (alu_op_select)
            4'b0000: alu_result_lo = alu_operand_a + alu_operand_b;
            4'b0001: alu_result_lo = alu_operand_a - alu_operand_b;
            4'b0101: alu_result_lo = ~alu_operand_a;
            4'b1000: alu_result_lo = alu_operand_a | alu_operand_b;
            4'b1001: alu_result_lo = alu_operand_a ^ alu_operand_b;
            4'b1100: alu_result_lo = alu_operand_a << alu_operand_b[4:0];
            4'b1101: alu_result_lo = alu_operand_a >> alu_operand_b[4:0];
            4'b1111: alu_result_lo = alu_operand_a & alu_operand_b;
            default: alu_result_lo = 32'h0;
        endcase
    end

    // Watch every cycle for a pop and a push requested together.
    always @(negedge clk) begin
        if (stack_pop && stack_push) begin
            overlapCount <= overlapCount + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one opcode and service the stack until done, checking the result path.
    task automatic applyStimulus(input vec_t v, input int idx);
        int          cyc;
        int          popIdx;
        int          popWait;
        int          pushWait;
        int          pushCount;
        int          doneCycle;
        int          illegalSeen;
        logic        finished;
        logic [31:0] pushed;
        logic [31:0] lastData;

        cyc = 0; popIdx = 0; popWait = 0; pushWait = 0; pushCount = 0;
        doneCycle = -1; illegalSeen = 0; finished = 1'b0;
        pushed = 32'h0; lastData = 32'h0;

        @(negedge clk);
        checkOutput($sformatf("v%0d.readyAtAccept", idx), 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_code  = v.op;
        stack_pop_valid  = 1'b0;
        stack_push_ready = 1'b0;

        while (!finished && cyc < 60) begin
            @(negedge clk);
            cyc++;
            op_code          = 4'b0011;
            stack_pop_valid  = 1'b0;
            stack_push_ready = 1'b0;
            stack_pop_data   = 32'hDEADBEEF;
            if (illegal_op) illegalSeen++;
            if (done) begin
                doneCycle = cyc;
                op_valid  = 1'b0;
                finished  = 1'b1;
            end
            if (stack_pop) begin
                if (popWait == v.popDelay) begin
                    stack_pop_valid = 1'b1;
                    stack_pop_data  = (popIdx == 0) ? v.top : v.second;
                    popIdx++;
                    popWait = 0;
                end else begin
                    popWait++;
                end
            end
            if (stack_push) begin
                if (pushWait > 0) begin
                    checkOutput($sformatf("v%0d.pushDataStable", idx), stack_push_data, lastData);
                end
                lastData = stack_push_data;
                if (pushWait == v.pushDelay) begin
                    stack_push_ready = 1'b1;
                    pushed = stack_push_data;
                    pushCount++;
                    pushWait = 0;
                    checkOutput($sformatf("v%0d.operandA", idx), alu_operand_a, v.expA);
                    checkOutput($sformatf("v%0d.operandB", idx), alu_operand_b, v.expB);
                    checkOutput($sformatf("v%0d.opSelect", idx), 32'(alu_op_select), 32'(v.op));
                end else begin
                    pushWait++;
                end
            end
        end
        op_valid = 1'b0;

        if (!finished) begin
            $display("[TB] FAIL v%0d.timeout: no done within 60 cycles", idx);
        end
        checkOutput($sformatf("v%0d.pushValue", idx), pushed, v.expPush);
        checkOutput($sformatf("v%0d.popCount", idx), 32'(popIdx), 32'(v.expPops));
        checkOutput($sformatf("v%0d.pushCount", idx), 32'(pushCount), 32'd1);
        checkOutput($sformatf("v%0d.doneCycle", idx), 32'(doneCycle), 32'(v.expDone));
        checkOutput($sformatf("v%0d.noIllegal", idx), 32'(illegalSeen), 32'd0);

        @(negedge clk);
        checkOutput($sformatf("v%0d.doneSingle", idx), 32'(done), 32'd0);
        checkOutput($sformatf("v%0d.readyAfter", idx), 32'(op_ready), 32'd1);
    endtask

    logic [3:0] illegalCodes[8];
    vec_t       iorVec;
    int         doneSeen;

    initial begin
        //            op       top           second        pD pP expPush       expA          expB          pops done
        vecs[0] = '{4'b0000, 32'h00000003, 32'h00000005, 0, 0, 32'h00000008, 32'h00000005, 32'h00000003, 2, 5};
        vecs[1] = '{4'b0001, 32'h00000003, 32'h0000000A, 2, 0, 32'h00000007, 32'h0000000A, 32'h00000003, 2, 9};
        vecs[2] = '{4'b0101, 32'h00000000, 32'h00000000, 0, 0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1, 4};
        vecs[3] = '{4'b1111, 32'hF0F0F0F0, 32'hFF00FF00, 0, 3, 32'hF000F000, 32'hFF00FF00, 32'hF0F0F0F0, 2, 8};
        vecs[4] = '{4'b1001, 32'h0000FFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 2, 5};
        vecs[5] = '{4'b1100, 32'h00000004, 32'h00000001, 0, 0, 32'h00000010, 32'h00000001, 32'h00000004, 2, 5};
        vecs[6] = '{4'b1101, 32'h00000008, 32'h80000000, 0, 0, 32'h00800000, 32'h80000000, 32'h00000008, 2, 5};
        vecs[7] = '{4'b0001, 32'h00000001, 32'h00000000, 0, 0, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 2, 5};
        vecs[8] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 1, 1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 2, 8};
        vecs[9] = '{4'b0101, 32'h00000005, 32'h00000000, 1, 0, 32'hFFFFFFFA, 32'h00000005, 32'h00000000, 1, 5};
        iorVec  = '{4'b1000, 32'h00000001, 32'h00000002, 0, 0, 32'h00000003, 32'h00000002, 32'h00000001, 2, 5};

        illegalCodes = '{4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1010, 4'b1011, 4'b1110};

        rst = 1'b1;
        op_valid = 1'b0;
        op_code = 4'b0000;
        stack_pop_valid = 1'b0;
        stack_pop_data = 32'h0;
        stack_push_ready = 1'b0;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        checkOutput("rst.opReady", 32'(op_ready), 32'd0);
        checkOutput("rst.stackPop", 32'(stack_pop), 32'd0);
        checkOutput("rst.stackPush", 32'(stack_push), 32'd0);
        checkOutput("rst.pushData", stack_push_data, 32'h0);
        checkOutput("rst.operandA", alu_operand_a, 32'h0);
        checkOutput("rst.operandB", alu_operand_b, 32'h0);
        checkOutput("rst.opSelect", 32'(alu_op_select), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.illegal", 32'(illegal_op), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst.opReadyAfter", 32'(op_ready), 32'd1);

        // Table of legal operations.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Unsupported opcodes: single illegal pulse, no stack traffic.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op_code  = illegalCodes[i];
            @(negedge clk);
            op_valid = 1'b0;
            checkOutput($sformatf("ill%0d.pulse", i), 32'(illegal_op), 32'd1);
            checkOutput($sformatf("ill%0d.noPop", i), 32'(stack_pop), 32'd0);
            checkOutput($sformatf("ill%0d.noPush", i), 32'(stack_push), 32'd0);
            checkOutput($sformatf("ill%0d.ready", i), 32'(op_ready), 32'd1);
            @(negedge clk);
            checkOutput($sformatf("ill%0d.pulseEnd", i), 32'(illegal_op), 32'd0);
            checkOutput($sformatf("ill%0d.noPopLater", i), 32'(stack_pop), 32'd0);
        end

        // Reset while waiting on the second pop.
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 4'b0000;
        @(negedge clk);
        op_valid = 1'b0;
        checkOutput("rstPopA.popB", 32'(stack_pop), 32'd1);
        stack_pop_valid = 1'b1;
        stack_pop_data  = 32'h00000011;
        @(negedge clk);
        stack_pop_valid = 1'b0;
        checkOutput("rstPopA.popA", 32'(stack_pop), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstPopA.popCleared", 32'(stack_pop), 32'd0);
        checkOutput("rstPopA.doneLow", 32'(done), 32'd0);
        checkOutput("rstPopA.opReadyInRst", 32'(op_ready), 32'd0);
        checkOutput("rstPopA.operandBCleared", alu_operand_b, 32'h0);
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || illegal_op || stack_pop || stack_push) doneSeen++;
        end
        checkOutput("rstPopA.quietAfter", 32'(doneSeen), 32'd0);
        checkOutput("rstPopA.opReadyAfter", 32'(op_ready), 32'd1);

        applyStimulus(iorVec, 10);

        checkOutput("popPushExclusive", 32'(overlapCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: op_valid  in  1  opcode request; op_code  in  4  ALU opcode; op_ready  out  1  sequencer can accept opcode.
REQ-004 SHALL have ports: stack_pop  out  1  pop request; stack_pop_valid  in  1  pop data valid; stack_pop_data  in  32  popped word.
REQ-005 SHALL have ports: stack_push  out  1  push request; stack_push_ready  in  1  stack accepts push; stack_push_data  out  32  word to push.
REQ-006 SHALL have ports: alu_operand_a  out  32; alu_operand_b  out  32; alu_op_select  out  4; alu_result_lo  in  32 (combinational ALU result).
REQ-007 SHALL have ports: done  out  1  one-cycle completion pulse; illegal_op  out  1  one-cycle unsupported-opcode pulse.

Function
REQ-010 SHALL treat as supported: 0000 IADD, 0001 ISUB, 0101 INEG, 1000 IOR, 1001 IXOR, 1100 ISHL, 1101 ISHR, 1111 IAND; all other codes (incl. 0010/0011/0100) unsupported.
REQ-011 SHALL implement states IDLE, POP_B, POP_A, EXEC, PUSH, DONE.
REQ-012 SHALL drive op_ready high only in IDLE; an opcode is accepted on a cycle with op_valid && op_ready, latched into op register.
REQ-013 SHALL on acceptance of a supported binary opcode go IDLE->POP_B; INEG goes IDLE->POP_A; unsupported code stays IDLE, pulses illegal_op next cycle, performs no pop/push.
REQ-014 SHALL hold stack_pop high throughout POP_B/POP_A; pop completes on the cycle stack_pop_valid is high, stack_pop_data captured that edge.
REQ-015 SHALL capture the first (top-of-stack) pop as operand_b and the second as operand_a; POP_B->POP_A, POP_A->EXEC on completion; no timeout.
REQ-016 SHALL for INEG perform exactly one pop into operand_a; operand_b forced to 0.
REQ-017 SHALL drive alu_operand_a/alu_operand_b/alu_op_select from the registered operands and opcode, stable from POP_A exit through PUSH.
REQ-018 SHALL in EXEC (exactly one cycle) register alu_result_lo into result register, then go to PUSH.
REQ-019 SHALL in PUSH hold stack_push high with stack_push_data = result register until stack_push_ready high; push completes that cycle; PUSH->DONE.
REQ-020 SHALL pulse done for exactly one cycle in DONE, then return to IDLE (op_ready high next cycle).
REQ-021 SHALL never assert stack_pop and stack_push in the same cycle.
REQ-022 SHALL achieve, with zero-wait stack, binary-op latency: accept at cycle 0, pops at 1 and 2, EXEC 3, push 4, done 5, op_ready 6; INEG one cycle shorter.
REQ-023 SHALL ignore op_valid outside IDLE; op_code changes mid-operation have no effect.
REQ-024 SHALL pass all 32-bit values unmodified; shift masking and arithmetic wrap are ALU responsibility.

Reset
REQ-030 SHALL on rst high at any clock edge enter IDLE, abandoning any in-flight pop/push, with no done/illegal_op pulse.
REQ-031 SHALL reset outputs: op_ready 0 during rst, 1 first cycle after; stack_pop 0; stack_push 0; stack_push_data 0; alu_operand_a/b 0; alu_op_select 0000; done 0; illegal_op 0.
REQ-032 SHALL clear operand, opcode and result registers to 0 on reset.

Verification
REQ-040 IADD, stack top 3 then 5, zero wait -> operands a=5 b=3, push 0x00000008, done at cycle 5.
REQ-041 ISUB, pops 3 (top) then 10, stack_pop_valid delayed 2 cycles each -> push 0x00000007, done only after both pops.
REQ-042 INEG, top 0x00000000 -> exactly one pop, operand_b 0, push 0xFFFFFFFF.
REQ-043 IAND 0xF0F0F0F0/0xFF00FF00, stack_push_ready low 3 cycles -> stack_push/data held stable 4 cycles, push 0xF000F000, single done.
REQ-044 op_code 0011 -> illegal_op pulse one cycle, no stack_pop/stack_push, op_ready high following cycle.
REQ-045 rst asserted in POP_A -> next cycle IDLE, stack_pop 0, no done; subsequent IOR 0x1/0x2 pushes 0x00000003.
